// File: rtl/clic_gateway.sv
// Per-source CLIC interrupt gateway: synchronises raw interrupt lines, applies
// polarity and level/edge selection, and keeps the pending and lost bits that
// feed the target arbiter. All per-source logic is one bit wide and replicated.
module clic_gateway #(
    parameter int N_SOURCE   = 256,
    parameter int SyncStages = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_SOURCE-1:0]      irq_src_i,
    input  logic [N_SOURCE-1:0][1:0] trig_i,
    input  logic [N_SOURCE-1:0]      ip_wr_i,
    input  logic [N_SOURCE-1:0]      ip_wdata_i,
    input  logic [N_SOURCE-1:0]      claim_i,
    output logic [N_SOURCE-1:0]      ip_o,
    output logic [N_SOURCE-1:0]      le_o,
    output logic [N_SOURCE-1:0]      lost_o
);

    logic [N_SOURCE-1:0] src_sync;
    logic [N_SOURCE-1:0] lvl;
    logic [N_SOURCE-1:0] edge_hit;
    logic [N_SOURCE-1:0] prev_q;
    logic [N_SOURCE-1:0] ip_q;
    logic [N_SOURCE-1:0] ip_d;
    logic [N_SOURCE-1:0] lost_q;
    logic [N_SOURCE-1:0] lost_d;
    logic                armed_q;

    generate
        if (SyncStages == 0) begin : g_bypass
            assign src_sync = irq_src_i;
        end else begin : g_sync
            logic [SyncStages-1:0][N_SOURCE-1:0] sync_q;

            // Shift raw lines through the synchroniser chain.
            // NOTE: the sync flops are reset as well, so a line that was high
            // before reset cannot leak through as a stale level afterwards.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= irq_src_i;
                    for (int s = 1; s < SyncStages; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end

            assign src_sync = sync_q[SyncStages-1];
        end
    endgenerate

    // Polarity correction and trigger-mode extraction per source.
    always_comb begin
        for (int i = 0; i < N_SOURCE; i++) begin
            lvl[i]  = src_sync[i] ^ trig_i[i][1];
            le_o[i] = trig_i[i][0];
        end
    end

    // armed_q masks the first cycle after reset, when prev_q is still zero
    // and an active-low source sitting low would otherwise look like an edge.
    assign edge_hit = {N_SOURCE{armed_q}} & lvl & ~prev_q;

    // Next pending / lost state: level mode tracks lvl, edge mode applies
    // edge > software write > claim > hold.
    // NOTE: every output gets a default before the branches, so no latch is inferred.
    always_comb begin
        ip_d   = ip_q;
        lost_d = lost_q;
        for (int i = 0; i < N_SOURCE; i++) begin
            if (!trig_i[i][0]) begin
                ip_d[i] = lvl[i];
            end else begin
                if (edge_hit[i]) begin
                    ip_d[i] = 1'b1;
                end else if (ip_wr_i[i]) begin
                    ip_d[i] = ip_wdata_i[i];
                end else if (claim_i[i]) begin
                    ip_d[i] = 1'b0;
                end

                if (edge_hit[i] && ip_q[i]) begin
                    lost_d[i] = 1'b1;
                end else if (ip_wr_i[i]) begin
                    lost_d[i] = 1'b0;
                end
            end
        end
    end

    // State registers: edge history, arming flag, pending and lost bits.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q  <= '0;
            armed_q <= 1'b0;
            ip_q    <= '0;
            lost_q  <= '0;
        end else begin
            prev_q  <= lvl;
            armed_q <= 1'b1;
            ip_q    <= ip_d;
            lost_q  <= lost_d;
        end
    end

    assign ip_o   = ip_q;
    assign lost_o = lost_q;

    // The arbiter claims at most one source per cycle.
    a_claim_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(claim_i));

    // Structural parameter limits.
    a_sync_stages : assert property (@(posedge clk_i) SyncStages >= 0 && SyncStages <= 3);
    a_n_source    : assert property (@(posedge clk_i) N_SOURCE >= 2);

endmodule
